mul16_pp_scheduler: RTL and testbench
=====================================

// Module: mul16_pp_scheduler
// PURPOSE
//  Sequences a 16x16 unsigned multiply through a shared pair of external 8x8 multipliers.
//  - Splits operands into bytes and issues the four partial products over two cycles.
//  - Accumulates the products with the correct shifts and returns a 32-bit result.
//  - Also supports a SEW8 mode: two independent 8x8 lane products, issued in one cycle.
//  - Sits between the execution-unit issue logic and the bit_16 multiplier lanes.
// PARAMETERS
//  MUL_LAT  1  cycles from operands driven on mul_a*/mul_b* to products valid on mul_p*; legal 1..4
// PORTS
//  clk        in   1   clock; all logic on posedge
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   request valid
//  in_ready   out  1   scheduler can accept a request
//  sew8       in   1   0: one 16x16 product; 1: two 8x8 lane products; sampled at accept
//  op_a       in   16  multiplicand {A_H,A_L}
//  op_b       in   16  multiplier {B_H,B_L}
//  mul_en     out  1   operands on mul_a*/mul_b* are valid this cycle
//  mul_a0     out  8   multiplier-0 operand A
//  mul_b0     out  8   multiplier-0 operand B
//  mul_a1     out  8   multiplier-1 operand A
//  mul_b1     out  8   multiplier-1 operand B
//  mul_p0     in   16  multiplier-0 product, valid MUL_LAT cycles after issue
//  mul_p1     in   16  multiplier-1 product, valid MUL_LAT cycles after issue
//  out_valid  out  1   result valid
//  out_ready  in   1   consumer accepts result
//  result     out  32  product
// BEHAVIOUR
//  Reset values: in_ready=0 during reset, 1 the cycle after; all other outputs 0; FSM=IDLE.
//  FSM states: IDLE -> ISSUE0 -> [ISSUE1] -> DRAIN -> DONE -> IDLE.
//   - IDLE: in_ready=1. On in_valid && in_ready at cycle T:
//       latch op_a, op_b, sew8; clear the accumulator; go to ISSUE0.
//   - ISSUE0 (T+1): mul_en=1; mul0 = A_L x B_L; mul1 = A_H x B_H.
//       next = sew8 ? DRAIN : ISSUE1.
//   - ISSUE1 (T+2): mul_en=1; mul0 = A_L x B_H; mul1 = A_H x B_L; next = DRAIN.
//   - DRAIN: wait for the last phase product to be captured, then go to DONE.
//   - DONE: out_valid=1; result held stable until out_ready; on out_valid && out_ready go to IDLE.
//  Phase tracking:
//   - A MUL_LAT-deep shift register of {valid, phase} tracks each issue.
//   - Products are captured when the tag emerges, i.e. at issue cycle + MUL_LAT.
//  Arithmetic (unsigned):
//   - Phase 0: acc = {p1, p0}, i.e. (HH<<16) + LL.
//   - Phase 1: acc += (p0 + p1) << 8. The cross sum is 17 bits; carry is kept.
//   - acc is 33 bits internally; result = acc[31:0], which never overflows for 16x16.
//   - sew8=1: result = {A_H*B_H, A_L*B_L}; no cross terms.
//  Latency (accept at T -> first out_valid):
//   - sew8=0: T+3+MUL_LAT.
//   - sew8=1: T+2+MUL_LAT.
//  Throughput: one request in flight; in_ready=0 outside IDLE; no accept in the same cycle as the DONE handshake.
//  Idle outputs: mul_a*/mul_b* = 0 whenever mul_en=0, for power and determinism.
//  out_ready=0 in DONE: stall indefinitely; result and out_valid stable.
//  rst mid-operation:
//   - Abort and discard in-flight products; tag pipe cleared.
//   - Next cycle is IDLE with out_valid=0.
//  in_valid while busy: ignored; the request is not consumed.
// TESTING
//  1. sew8=0, A=0x5678, B=0x1234, MUL_LAT=1 -> mul0 gets 0x78/0x34 then 0x78/0x12.
//     Expected result=0x06260060 at T+4.
//  2. sew8=1, A=0x5678, B=0x1234 -> single issue cycle; result=0x060C1860 at T+3.
//  3. sew8=0, A=0xFFFF, B=0xFFFF -> result=0xFFFE0001; checks cross-sum carry (0x1FC02).
//  4. out_ready held 0 for 5 cycles in DONE -> result/out_valid stable; in_ready=0;
//     a new in_valid is not accepted until after the handshake.
//  5. rst=1 in ISSUE1 -> next cycle IDLE, out_valid=0.
//     Then A=0x0002, B=0x0003 -> result=0x00000006.
//  6. MUL_LAT=3, 100 random back-to-back requests, random sew8 and out_ready
//     -> every result matches the reference model; latency 6 (sew8=0) or 5 (sew8=1).

Source files
------------

// File: rtl/mul16_pp_scheduler.sv
// ---------------------------------------------------------------------------
// mul16_pp_scheduler
//
// Runs one 16x16 unsigned multiply through a shared pair of external 8x8
// multipliers. The four byte partial products are issued over two cycles and
// summed with the right shifts into a 32-bit result. In SEW8 mode the two
// lanes are independent 8x8 products, issued in one cycle, with no cross terms.
//
// Ports
//   clk, rst              clock (posedge) and synchronous active-high reset
//   in_valid / in_ready   request handshake; op_a, op_b, sew8 latched on accept
//   sew8                  0: one 16x16 product, 1: two 8x8 lane products
//   op_a, op_b            operands {hi byte, lo byte}
//   mul_en                mul_a0/b0/a1/b1 carry valid operands this cycle
//   mul_a0, mul_b0        multiplier-0 operands (0 when mul_en = 0)
//   mul_a1, mul_b1        multiplier-1 operands (0 when mul_en = 0)
//   mul_p0, mul_p1        products, valid MUL_LAT cycles after issue
//   out_valid / out_ready result handshake; result held until accepted
//   result                32-bit product
// ---------------------------------------------------------------------------
module mul16_pp_scheduler #(
    parameter int MUL_LAT = 1   // external multiplier latency, 1..4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sew8,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        mul_en,
    output logic [7:0]  mul_a0,
    output logic [7:0]  mul_b0,
    output logic [7:0]  mul_a1,
    output logic [7:0]  mul_b1,
    input  logic [15:0] mul_p0,
    input  logic [15:0] mul_p1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE0 = 3'd1,
        ISSUE1 = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t state_reg, state_next;

    logic [15:0] a_reg, b_reg;
    logic        sew8_reg;
    logic [32:0] acc_reg;

    // Tag pipe: one {valid, phase} entry per issue, MUL_LAT deep, so the tag
    // leaves the last stage in the same cycle its products sit on mul_p*.
    logic [MUL_LAT-1:0] tag_valid_reg, tag_valid_next;
    logic [MUL_LAT-1:0] tag_phase_reg, tag_phase_next;
    logic               issue_phase;
    logic               tag_out_valid, tag_out_phase;

    logic        accept;
    logic [16:0] cross_sum;

    assign in_ready  = (state_reg == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_reg == DONE);
    assign result    = acc_reg[31:0];

    assign tag_valid_next[0] = mul_en;
    assign tag_phase_next[0] = issue_phase;

    genvar gi;
    generate
        for (gi = 1; gi < MUL_LAT; gi++) begin : g_tag_shift
            assign tag_valid_next[gi] = tag_valid_reg[gi-1];
            assign tag_phase_next[gi] = tag_phase_reg[gi-1];
        end
    endgenerate

    assign tag_out_valid = tag_valid_reg[MUL_LAT-1];
    assign tag_out_phase = tag_phase_reg[MUL_LAT-1];

    // Cross products can each reach 0xFE01; their sum needs the 17th bit.
    assign cross_sum = {1'b0, mul_p0} + {1'b0, mul_p1};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            tag_valid_reg <= '0;
            tag_phase_reg <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            sew8_reg      <= 1'b0;
            acc_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            tag_valid_reg <= tag_valid_next;
            tag_phase_reg <= tag_phase_next;
            if (accept) begin
                a_reg    <= op_a;
                b_reg    <= op_b;
                sew8_reg <= sew8;
                acc_reg  <= '0;
            end else if (tag_out_valid) begin
                if (!tag_out_phase) begin
                    // HH lands in the upper half, LL in the lower half; in
                    // SEW8 mode this is already the pair of lane products.
                    acc_reg <= {1'b0, mul_p1, mul_p0};
                end else begin
                    acc_reg <= acc_reg + {8'd0, cross_sum, 8'd0};
                end
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        mul_en      = 1'b0;
        issue_phase = 1'b0;
        mul_a0      = 8'd0;
        mul_b0      = 8'd0;
        mul_a1      = 8'd0;
        mul_b1      = 8'd0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = ISSUE0;
                end
            end
            ISSUE0: begin
                mul_en     = 1'b1;
                mul_a0     = a_reg[7:0];
                mul_b0     = b_reg[7:0];
                mul_a1     = a_reg[15:8];
                mul_b1     = b_reg[15:8];
                state_next = sew8_reg ? DRAIN : ISSUE1;
            end
            ISSUE1: begin
                mul_en      = 1'b1;
                issue_phase = 1'b1;
                mul_a0      = a_reg[7:0];
                mul_b0      = b_reg[15:8];
                mul_a1      = a_reg[15:8];
                mul_b1      = b_reg[7:0];
                state_next  = DRAIN;
            end
            DRAIN: begin
                // The last phase is 0 in SEW8 mode, 1 otherwise.
                if (tag_out_valid && (tag_out_phase == !sew8_reg)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mul16_pp_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mul16_pp_scheduler
//
// Drives mul16_pp_scheduler (MUL_LAT = 3) with directed and random requests.
// A bench-side multiplier pair returns products L cycles after issue (garbage
// when nothing was issued). A cycle-level model derives every expected output
// from the request history; selected requests also carry hand-computed
// result and latency values.
// ---------------------------------------------------------------------------
module tb_mul16_pp_scheduler;

    localparam int L = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sew8 = 1'b0;
    logic [15:0] op_a = 16'd0;
    logic [15:0] op_b = 16'd0;
    logic        mul_en;
    logic [7:0]  mul_a0, mul_b0, mul_a1, mul_b1;
    logic [15:0] mul_p0, mul_p1;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;

    mul16_pp_scheduler #(.MUL_LAT(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sew8      (sew8),
        .op_a      (op_a),
        .op_b      (op_b),
        .mul_en    (mul_en),
        .mul_a0    (mul_a0),
        .mul_b0    (mul_b0),
        .mul_a1    (mul_a1),
        .mul_b1    (mul_b1),
        .mul_p0    (mul_p0),
        .mul_p1    (mul_p1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    // External 8x8 multipliers with latency L.
    logic [15:0] p0_pipe [L];
    logic [15:0] p1_pipe [L];
    always @(posedge clk) begin
        for (int i = L - 1; i > 0; i--) begin
            p0_pipe[i] <= p0_pipe[i-1];
            p1_pipe[i] <= p1_pipe[i-1];
        end
        p0_pipe[0] <= mul_en ? 16'(mul_a0) * 16'(mul_b0) : 16'($urandom);
        p1_pipe[0] <= mul_en ? 16'(mul_a1) * 16'(mul_b1) : 16'($urandom);
    end
    assign mul_p0 = p0_pipe[L-1];
    assign mul_p1 = p1_pipe[L-1];

    // Stimulus -> checker channel for hand-computed expectations.
    int          pin_seq  = 0;
    logic [31:0] pin_exp  = 32'd0;
    int          pin_lat  = 0;
    logic        stim_tmo = 1'b0;
    logic        rand_mode = 1'b0;

    // Checker state.
    int          n_checks = 0;
    int          n_fails  = 0;
    logic        m_busy = 1'b0;
    int          m_k = 0;
    logic [15:0] m_a = 16'd0, m_b = 16'd0;
    logic        m_s = 1'b0;
    logic        m_after_rst = 1'b0;
    int          pin_done = 0;
    logic        cur_pinned = 1'b0;
    logic        pin_seen = 1'b0;
    logic [31:0] cur_exp = 32'd0;
    int          cur_lat = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] model_result(input logic [15:0] a, input logic [15:0] b,
                                                 input logic s);
        int unsigned ah, al, bh, bl;
        ah = 32'(a[15:8]); al = 32'(a[7:0]);
        bh = 32'(b[15:8]); bl = 32'(b[7:0]);
        if (s) return ((ah * bh) << 16) | (al * bl);
        return 32'(a) * 32'(b);
    endfunction

    always @(negedge clk) begin
        logic [32:0] exp_mul;
        int          lat;
        chk("stim_timeout", {63'd0, stim_tmo}, 64'd0);
        if (rst) begin
            chk("in_ready_rst", {63'd0, in_ready}, 64'd0);
            m_busy      = 1'b0;
            m_after_rst = 1'b1;
            cur_pinned  = 1'b0;
        end else begin
            if (m_after_rst) begin
                chk("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
                chk("post_rst_result", {32'd0, result}, 64'd0);
                m_after_rst = 1'b0;
            end
            if (!m_busy) begin
                chk("in_ready", {63'd0, in_ready}, 64'd1);
                chk("out_valid", {63'd0, out_valid}, 64'd0);
                chk("mul_bus", {31'd0, mul_en, mul_a0, mul_b0, mul_a1, mul_b1}, 64'd0);
                if (in_valid) begin
                    m_busy = 1'b1;
                    m_k    = 0;
                    m_a    = op_a;
                    m_b    = op_b;
                    m_s    = sew8;
                    if (pin_seq != pin_done) begin
                        cur_pinned = 1'b1;
                        cur_exp    = pin_exp;
                        cur_lat    = pin_lat;
                        pin_done   = pin_seq;
                        pin_seen   = 1'b0;
                    end else begin
                        cur_pinned = 1'b0;
                    end
                end
            end else begin
                m_k++;
                lat = m_s ? 2 + L : 3 + L;
                exp_mul = '0;
                if (m_k == 1)
                    exp_mul = {1'b1, m_a[7:0], m_b[7:0], m_a[15:8], m_b[15:8]};
                else if (m_k == 2 && !m_s)
                    exp_mul = {1'b1, m_a[7:0], m_b[15:8], m_a[15:8], m_b[7:0]};
                chk("mul_bus", {31'd0, mul_en, mul_a0, mul_b0, mul_a1, mul_b1}, {31'd0, exp_mul});
                chk("in_ready_busy", {63'd0, in_ready}, 64'd0);
                chk("out_valid", {63'd0, out_valid}, {63'd0, m_k >= lat});
                if (m_k >= lat) begin
                    chk("result", {32'd0, result}, {32'd0, model_result(m_a, m_b, m_s)});
                end
                if (out_valid && cur_pinned && !pin_seen) begin
                    chk("pin_result", {32'd0, result}, {32'd0, cur_exp});
                    chk("pin_latency", 64'(m_k), 64'(cur_lat));
                    pin_seen = 1'b1;
                end
                if (m_k >= lat && out_ready) m_busy = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_mode) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic arm(input logic [31:0] exp, input int lat);
        pin_exp = exp;
        pin_lat = lat;
        pin_seq++;
    endtask

    task automatic do_req(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic hs;
        hs       = 1'b0;
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        sew8     = s;
        for (int n = 0; n < 300 && !hs; n++) begin
            @(negedge clk);
            hs = in_ready;
            step();
        end
        if (!hs) stim_tmo = 1'b1;
        in_valid = 1'b0;
        op_a     = 16'($urandom);
        op_b     = 16'($urandom);
        sew8     = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        if (!out_valid) stim_tmo = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        rst = 1'b0;
        step();

        // 16x16 basic
        arm(32'h0626_0060, 6);
        do_req(16'h5678, 16'h1234, 1'b0);
        wait_valid();
        step();

        // SEW8 lanes
        arm(32'h060C_1860, 5);
        do_req(16'h5678, 16'h1234, 1'b1);
        wait_valid();
        step();

        // cross-sum carry
        arm(32'hFFFE_0001, 6);
        do_req(16'hFFFF, 16'hFFFF, 1'b0);
        wait_valid();
        step();

        // stall in DONE with a pending request that must not be taken early
        out_ready = 1'b0;
        arm(32'h0246_8642, 6);
        do_req(16'h1111, 16'h2222, 1'b0);
        wait_valid();
        arm(32'h0A05_0C03, 5);
        in_valid = 1'b1;
        op_a     = 16'hABCD;
        op_b     = 16'h0F0F;
        sew8     = 1'b1;
        repeat (5) step();
        out_ready = 1'b1;
        do_req(16'hABCD, 16'h0F0F, 1'b1);
        wait_valid();
        step();

        // reset during ISSUE1, then a fresh request
        do_req(16'h9999, 16'h7777, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        arm(32'h0000_0006, 6);
        do_req(16'h0002, 16'h0003, 1'b0);
        wait_valid();
        step();

        // random back-to-back traffic with random backpressure
        rand_mode = 1'b1;
        for (int i = 0; i < 100; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 9) == 0) a = 16'hFFFF;
            if ($urandom_range(0, 9) == 0) b = 16'h0000;
            do_req(a, b, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 4) == 0) step();
        end
        rand_mode = 1'b0;
        out_ready = 1'b1;
        repeat (30) step();

        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
